// File: rtl/crc32_check.sv
// rtl/crc32_check.sv - bit-serial CRC-32 receive checker with mismatch counter
//
// Purpose: accepts a 32-bit message word and the CRC received with it. It
// recomputes the CRC one bit per cycle, MSB first (init 0, no reflection, no
// final XOR), compares the result against the received CRC, and presents the
// result through a valid/ready handshake. It also keeps a saturating count of
// failed checks.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   in_valid_i   message/CRC pair present
//   in_ready_o   block can accept a pair (IDLE)
//   message_i    message word, bit 31 processed first
//   crc_rx_i     CRC received with the message
//   out_valid_o  result available (DONE)
//   out_ready_i  consumer takes result
//   crc_calc_o   recomputed CRC of the last completed message
//   crc_ok_o     1 when crc_calc_o matched the latched received CRC
//   err_count_o  saturating count of failed checks
//   clear_i      synchronous abort and counter clear, highest priority
module crc32_check #(
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter int          ERR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      message_i,
  input  logic [31:0]      crc_rx_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      crc_calc_o,
  output logic             crc_ok_o,
  output logic [ERR_W-1:0] err_count_o,
  input  logic             clear_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [31:0]      msg_q;
  logic [31:0]      rx_q;
  logic [31:0]      lfsr_q;
  logic [4:0]       cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [31:0]      crc_calc_q;
  logic             crc_ok_q;
  logic [ERR_W-1:0] err_q;

  // One LFSR step on the current message MSB.
  logic        fb;
  logic [31:0] lfsr_d;

  always_comb begin
    fb     = lfsr_q[31] ^ msg_q[31];
    lfsr_d = {lfsr_q[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      rx_q        <= '0;
      lfsr_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      crc_calc_q  <= '0;
      crc_ok_q    <= 1'b0;
      err_q       <= '0;
    end else if (clear_i) begin
      // Abort whatever is in flight; the result registers keep their values.
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            msg_q      <= message_i;
            rx_q       <= crc_rx_i;
            lfsr_q     <= '0;
            cnt_q      <= 5'd31;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr_q <= lfsr_d;
          msg_q  <= {msg_q[30:0], 1'b0};
          cnt_q  <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            // lfsr_d already includes the last bit.
            crc_calc_q  <= lfsr_d;
            crc_ok_q    <= (lfsr_d == rx_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
            if ((lfsr_d != rx_q) && !(&err_q)) begin
              err_q <= err_q + ERR_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign crc_calc_o  = crc_calc_q;
  assign crc_ok_o    = crc_ok_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_crc32_check.sv
// tb/tb_crc32_check.sv - directed self-checking bench for crc32_check
module tb_crc32_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] message;
  logic [31:0] crc_rx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] crc_calc;
  logic        crc_ok;
  logic [15:0] err_count;
  logic        clear;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] crc_calc2;
  logic        crc_ok2;
  logic [1:0]  err_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  crc32_check dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .message_i(message), .crc_rx_i(crc_rx), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .crc_calc_o(crc_calc), .crc_ok_o(crc_ok),
    .err_count_o(err_count), .clear_i(clear)
  );

  crc32_check #(.ERR_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .message_i(message), .crc_rx_i(crc_rx), .out_valid_o(out_valid2),
    .out_ready_i(out_ready), .crc_calc_o(crc_calc2), .crc_ok_o(crc_ok2),
    .err_count_o(err_count2), .clear_i(clear)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one pair for a single edge.
  task automatic send_pair(input logic [31:0] msg, input logic [31:0] rx);
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      tick();
    end
    message  = msg;
    crc_rx   = rx;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    message = '0; crc_rx = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || crc_calc !== 32'h0 ||
        crc_ok !== 1'b0 || err_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b calc=%h ok=%b err=%0d, required 1 0 00000000 0 0",
               in_ready, out_valid, crc_calc, crc_ok, err_count);
    end
  endtask

  task automatic test_zero();
    int early = 0;
    send_pair(32'h0, 32'h0);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy: in_ready=%b, required 0", in_ready);
    end
    for (int i = 0; i < 31; i++) begin
      tick();
      if (out_valid) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL zero_early: out_valid high on %0d of edges A+1..A+31, required 0", early);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || crc_calc !== 32'h0 || crc_ok !== 1'b1 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_result: vld=%b calc=%h ok=%b err=%0d, required 1 00000000 1 0",
               out_valid, crc_calc, crc_ok, err_count);
    end
    take_result();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_return: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_bit();
    bit seen;
    logic [31:0] msgs [2] = '{32'h00000001, 32'h00000002};
    logic [31:0] crcs [2] = '{32'h04C11DB7, 32'h09823B6E};
    for (int k = 0; k < 2; k++) begin
      send_pair(msgs[k], crcs[k]);
      wait_result(seen);
      n_checks++;
      if (!seen || crc_calc !== crcs[k] || crc_ok !== 1'b1 || err_count !== 16'd0) begin
        n_fail++;
        $display("FAIL single_bit[%0d]: seen=%b calc=%h ok=%b err=%0d, required 1 %h 1 0",
                 k, seen, crc_calc, crc_ok, err_count, crcs[k]);
      end
      take_result();
    end
  endtask

  task automatic test_mismatch();
    bit seen;
    send_pair(32'h00000003, 32'h0D4326D8);
    wait_result(seen);
    n_checks++;
    if (!seen || crc_calc !== 32'h0D4326D9 || crc_ok !== 1'b0 || err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL mismatch1: seen=%b calc=%h ok=%b err=%0d, required 1 0d4326d9 0 1",
               seen, crc_calc, crc_ok, err_count);
    end
    take_result();
    send_pair(32'h00000004, 32'h00000000);
    wait_result(seen);
    n_checks++;
    if (!seen || crc_calc !== 32'h130476DC || crc_ok !== 1'b0 || err_count !== 16'd2) begin
      n_fail++;
      $display("FAIL mismatch2: seen=%b calc=%h ok=%b err=%0d, required 1 130476dc 0 2",
               seen, crc_calc, crc_ok, err_count);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    bit seen;
    int bad = 0;
    send_pair(32'h00000002, 32'h09823B6E);
    wait_result(seen);
    for (int i = 0; i < 10; i++) begin
      message  = 32'hFFFF0000 | i;
      crc_rx   = 32'h0;
      in_valid = i[0];
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || crc_calc !== 32'h09823B6E ||
          crc_ok !== 1'b1 || err_count !== 16'd2) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!seen || bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: seen=%b unstable cycles=%0d, required 1 0", seen, bad);
    end
    take_result();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || crc_calc !== 32'h09823B6E) begin
      n_fail++;
      $display("FAIL backpressure_release: rdy=%b vld=%b calc=%h, required 1 0 09823b6e",
               in_ready, out_valid, crc_calc);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    send_pair(32'h00000003, 32'h00000000);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || crc_calc !== 32'h0 ||
        crc_ok !== 1'b0 || err_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_abort: rdy=%b vld=%b calc=%h ok=%b err=%0d, required 1 0 00000000 0 0",
               in_ready, out_valid, crc_calc, crc_ok, err_count);
    end
    tick();
    rst = 1'b0;
    send_pair(32'h00000001, 32'h04C11DB7);
    wait_result(seen);
    n_checks++;
    if (!seen || crc_calc !== 32'h04C11DB7 || crc_ok !== 1'b1 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_recover: seen=%b calc=%h ok=%b err=%0d, required 1 04c11db7 1 0",
               seen, crc_calc, crc_ok, err_count);
    end
    take_result();
  endtask

  task automatic test_clear_abort();
    bit seen;
    send_pair(32'h00000003, 32'h0D4326D8);
    wait_result(seen);
    take_result();
    n_checks++;
    if (err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL clear_pre: err=%0d, required 1", err_count);
    end
    send_pair(32'h00000001, 32'h00000000);
    for (int i = 0; i < 10; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (err_count !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        crc_calc !== 32'h0D4326D9 || crc_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_abort: err=%0d vld=%b rdy=%b calc=%h ok=%b, required 0 0 1 0d4326d9 0",
               err_count, out_valid, in_ready, crc_calc, crc_ok);
    end
    wait_result(seen);
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL clear_no_result: out_valid=%b after clear, required 0", seen);
    end
    // Clear coinciding with in_valid in IDLE must not accept the pair.
    message = 32'h1; crc_rx = 32'h0; in_valid = 1'b1; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_vs_valid: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_saturation();
    bit seen;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_pair(32'h00000003, 32'hDEADBEEF);
      wait_result(seen);
      take_result();
    end
    n_checks++;
    if (err_count2 !== 2'd3) begin
      n_fail++;
      $display("FAIL saturation: err_count(ERR_W=2)=%0d, required 3", err_count2);
    end
    n_checks++;
    if (err_count !== 16'd5) begin
      n_fail++;
      $display("FAIL count_wide: err_count=%0d, required 5", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_bit();
    test_mismatch();
    test_backpressure();
    test_reset_abort();
    test_clear_abort();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
